instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the MIPS core. It holds the program counter, issues word reads to instruction memory through a req/ack handshake, and captures the returned word in a one-entry instruction register (IR). It presents the IR, plus its opcode and funct fields, to the decode/control unit through a valid/ready handshake. It accepts PC redirects (taken branch, J/JAL/JR target) from the execute stage.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; **synchronous, active-low**.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  byte address of the fetch; always word-aligned.
- `imem_ack`  in  1  memory completed the request; `imem_rdata` is valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `redirect_valid`  in  1  single-cycle pulse; load `redirect_pc` into the PC.
- `redirect_pc`  in  32  new fetch address; bits [1:0] are ignored and forced to 00.
- `ins_valid`  out  1  IR holds a valid instruction.
- `ins_ready`  in  1  decode accepts the IR; a transfer occurs when `ins_valid && ins_ready`.
- `ins`  out  32  IR contents.
- `opcode`  out  6  `ins[31:26]`, the control-unit opcode input.
- `funct`  out  6  `ins[5:0]`.
- `ins_pc`  out  32  address of the instruction in the IR.
- `ins_pc_plus4`  out  32  `ins_pc + 4`, modulo 2^32.

## Operation
- **Registers:** `pc` (next fetch address), IR, `ins_valid`, `ins_pc`, FSM state.
- **IR space:** the IR can accept a new word when `!ins_valid || ins_ready`.
- **IDLE**
  - Entered on reset.
  - Holds for 1 cycle with `imem_req`=0, then goes to FETCH.
- **FETCH** (no request outstanding)
  - `imem_req` is driven combinationally as `(IR space) && !redirect_valid`.
  - `imem_addr` = `pc`.
  - If `imem_req && imem_ack`: load IR with `imem_rdata`, set `ins_valid`=1, set `ins_pc`=`pc`, set `pc`=`pc+4`, and stay in FETCH.
  - If `imem_req && !imem_ack`: go to WAIT.
- **WAIT** (request outstanding)
  - `imem_req`=1 and `imem_addr`=`pc`, both held stable until ack, regardless of `ins_ready`.
  - On ack: capture the word as in FETCH and return to FETCH. The IR is guaranteed empty at this point.
- **FLUSH** (outstanding request belongs to a squashed path)
  - `imem_req`=1 and `imem_addr` = the old address, held until ack.
  - On ack: discard the data and go to FETCH.
- **Redirect** (`redirect_valid`=1)
  - Sets `pc` = `{redirect_pc[31:2],2'b00}` and clears `ins_valid` at the next edge.
  - From FETCH: no request is issued that cycle; stay in FETCH.
  - From WAIT without ack: go to FLUSH. The old address is held in a shadow register.
  - From WAIT with ack in the same cycle: discard the data, go to FETCH with the new `pc`.
  - From FLUSH: update `pc`; remain in FLUSH.
  - A transfer in the same cycle as a redirect still counts as a transfer; squashing wrong-path instructions is decode's responsibility.
- **Decode transfer:** when a transfer occurs and no new word is captured, `ins_valid` goes to 0.
- **PC arithmetic:** all PC additions wrap modulo 2^32; 0xFFFF_FFFC + 4 = 0x0000_0000.
- **Reset mid-operation:** any outstanding request is abandoned and a same-cycle ack is ignored. The memory must tolerate `imem_req` dropping.

## Timing
- **Reset values** (while `rst_n`=0 at an edge):
  - state IDLE; `pc`=`RESET_PC`
  - `imem_req`=0; `imem_addr`=`RESET_PC`
  - `ins`=0, `opcode`=0, `funct`=0, `ins_valid`=0
  - `ins_pc`=`RESET_PC`; `ins_pc_plus4`=`RESET_PC`+4
- **First request:** `imem_req` first rises in the 2nd cycle after `rst_n` goes high.
- **Fetch latency:** with the ack in cycle n, `ins_valid`=1 in cycle n+1.
- **Throughput:** 1 instruction/cycle with zero-wait memory and `ins_ready` held at 1.
- **Redirect penalty:** a redirect in cycle n gives a request to the new PC in cycle n+1 (from FETCH), or 1 cycle after the flushed ack (from WAIT/FLUSH).
- **Memory contract:** `imem_ack` is only valid while `imem_req`=1; an ack without a request is ignored.

## Configuration
- **`IF_PERF_CNT_EN` defined:** adds two output ports, both reset to 0 and wrapping at 2^32.
  - `perf_fetched` (32 bits): increments on every IR capture.
  - `perf_stall` (32 bits): increments each cycle in which `ins_valid && !ins_ready`.
- **`IF_PERF_CNT_EN` undefined:** neither port nor counter exists; all other behaviour is identical.

## Test plan
- **Reset:** `RESET_PC`=0x0040_0000, `rst_n` low for 2 cycles.
  - Required: `imem_req`=0, `ins_valid`=0, `opcode`=0.
  - Required: 2 cycles after release, `imem_req`=1 with `imem_addr`=0x0040_0000.
- **Zero-wait streaming:** same-cycle ack returning 0x8C08_0004 (LW), 0xAC08_0008 (SW), 0x1109_0003 (BEQ); `ins_ready`=1.
  - Required: `ins_valid` on 3 consecutive cycles.
  - Required: `opcode` = 100011, 101011, 000100.
  - Required: `ins_pc` = 0x0040_0000, 0x0040_0004, 0x0040_0008.
- **Backpressure:** `ins_ready`=0 for 3 cycles with the IR full.
  - Required: `ins` is stable, `imem_req`=0, and `pc` does not advance.
  - Required: the 1st cycle with `ins_ready`=1 raises `imem_req`.
- **Wait states:** ack delayed 3 cycles.
  - Required: `imem_req`=1 and `imem_addr` constant throughout, even with `ins_ready` toggling.
  - Required: `ins_valid` rises the cycle after the ack.
- **Redirect:**
  - `redirect_pc`=0x0040_0103 asserted during WAIT, ack arriving 2 cycles later.
  - Required: the acked data is discarded and `ins_valid` stays 0.
  - Required: the next request is to 0x0040_0100.
- **Wrap and counters:**
  - `redirect_pc`=0xFFFF_FFFC followed by 2 fetches. Required: addresses are 0xFFFF_FFFC, then 0x0000_0000.
  - With `IF_PERF_CNT_EN` and the 5 fetches/3 stall cycles above: `perf_fetched`=5, `perf_stall`=3.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS instruction fetch stage.
// Holds the PC, fetches words over a req/ack memory port into a one-entry
// instruction register, and hands the IR to decode over valid/ready.
// Accepts PC redirects from execute. An outstanding fetch whose path has
// been squashed is drained in FLUSH and its data is dropped.
// Optional feature macro: IF_PERF_CNT_EN adds perf_fetched / perf_stall.
`timescale 1ns/1ps
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] ins_pc,
    output logic [31:0] ins_pc_plus4
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;          // next fetch address
    logic [31:0] flush_addr;  // address of the squashed request being drained

    logic        ir_space;
    logic        capture;
    logic        xfer;
    logic [31:0] redir_aligned;
    logic [31:0] pc_plus4;

    // The IR can take a word if empty or being drained by decode this cycle.
    assign ir_space      = !ins_valid || ins_ready;
    assign xfer          = ins_valid && ins_ready;
    assign redir_aligned = redirect_pc & ~32'd3;
    assign pc_plus4      = pc + 32'd4;

    // Request/address decode. FETCH only asks when the IR has room and no
    // redirect is pending; WAIT/FLUSH hold the request stable until ack.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        case (state)
            S_FETCH: imem_req = ir_space && !redirect_valid;
            S_WAIT:  imem_req = 1'b1;
            S_FLUSH: begin
                imem_req  = 1'b1;
                imem_addr = flush_addr;
            end
            default: imem_req = 1'b0;
        endcase
    end

    // A returned word is kept only if its request belongs to the live path.
    // A redirect in WAIT kills the same-cycle ack; FLUSH acks are always dropped.
    assign capture = imem_ack &&
                     (((state == S_FETCH) && imem_req) ||
                      ((state == S_WAIT) && !redirect_valid));

    // Fetch FSM: state, PC and the shadow address for a flushed request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            flush_addr <= RESET_PC;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
                    if (redirect_valid)
                        pc <= redir_aligned;
                end
                S_FETCH: begin
                    if (redirect_valid)
                        pc <= redir_aligned;
                    else if (capture)
                        pc <= pc_plus4;
                    else if (imem_req)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc <= redir_aligned;
                        if (imem_ack) begin
                            state <= S_FETCH;
                        end else begin
                            // memory still owns the old address; keep driving it
                            flush_addr <= pc;
                            state      <= S_FLUSH;
                        end
                    end else if (imem_ack) begin
                        pc    <= pc_plus4;
                        state <= S_FETCH;
                    end
                end
                S_FLUSH: begin
                    if (redirect_valid)
                        pc <= redir_aligned;
                    if (imem_ack)
                        state <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Instruction register and its valid flag. A redirect empties the IR;
    // a transfer in the same cycle has already been taken by decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ins       <= '0;
            ins_valid <= 1'b0;
            ins_pc    <= RESET_PC;
        end else begin
            if (redirect_valid)
                ins_valid <= 1'b0;
            else if (capture)
                ins_valid <= 1'b1;
            else if (xfer)
                ins_valid <= 1'b0;

            if (capture) begin
                ins    <= imem_rdata;
                ins_pc <= pc;
            end
        end
    end

    assign opcode       = ins[31:26];
    assign funct        = ins[5:0];
    assign ins_pc_plus4 = ins_pc + 32'd4;

`ifdef IF_PERF_CNT_EN
    // Performance counters: IR captures and decode backpressure cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (capture)
                perf_fetched <= perf_fetched + 32'd1;
            if (ins_valid && !ins_ready)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios plus a randomized run
// checked against a program-order model of the delivered instruction stream.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam logic [31:0] RST = 32'h0040_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] ins_pc;
    logic [31:0] ins_pc_plus4;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] sw_word [3] = '{32'h8C08_0004, 32'hAC08_0008, 32'h1109_0003};
    logic [5:0]  sw_op   [3] = '{6'b100011, 6'b101011, 6'b000100};

    instr_fetch_unit #(.RESET_PC(RST)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
        .opcode(opcode), .funct(funct),
        .ins_pc(ins_pc), .ins_pc_plus4(ins_pc_plus4)
`ifdef IF_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic test_reset();
        rst_n = 0; ins_ready = 0; redirect_valid = 0; redirect_pc = 0;
        imem_ack = 0; imem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b exp 0", imem_req); end
        n_vec++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", ins_valid); end
        n_vec++; if (opcode !== 6'd0) begin n_err++; $display("FAIL reset_opcode: got %h exp 0", opcode); end
        n_vec++; if (ins !== 32'd0) begin n_err++; $display("FAIL reset_ins: got %h exp 0", ins); end
        n_vec++; if (imem_addr !== RST) begin n_err++; $display("FAIL reset_addr: got %h exp %h", imem_addr, RST); end
        n_vec++; if (ins_pc !== RST) begin n_err++; $display("FAIL reset_ins_pc: got %h exp %h", ins_pc, RST); end
        n_vec++; if (ins_pc_plus4 !== RST + 32'd4) begin n_err++; $display("FAIL reset_plus4: got %h exp %h", ins_pc_plus4, RST + 32'd4); end
        rst_n = 1;
        #1;
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b exp 0", imem_req); end
        @(posedge clk); #1;
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b exp 1", imem_req); end
        n_vec++; if (imem_addr !== RST) begin n_err++; $display("FAIL first_addr: got %h exp %h", imem_addr, RST); end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 3; i++) begin
            ins_ready = 1; imem_ack = 1; imem_rdata = sw_word[i];
            #1;
            n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL stream_req[%0d]: got %b exp 1", i, imem_req); end
            n_vec++; if (imem_addr !== RST + 32'(4*i)) begin n_err++; $display("FAIL stream_addr[%0d]: got %h exp %h", i, imem_addr, RST + 32'(4*i)); end
            if (i > 0) begin
                n_vec++; if (ins_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b exp 1", i-1, ins_valid); end
                n_vec++; if (opcode !== sw_op[i-1]) begin n_err++; $display("FAIL stream_opcode[%0d]: got %b exp %b", i-1, opcode, sw_op[i-1]); end
                n_vec++; if (ins_pc !== RST + 32'(4*(i-1))) begin n_err++; $display("FAIL stream_ins_pc[%0d]: got %h exp %h", i-1, ins_pc, RST + 32'(4*(i-1))); end
            end
            @(posedge clk); #1;
        end
        imem_ack = 0; ins_ready = 0;
        #1;
        n_vec++; if (ins_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[2]: got %b exp 1", ins_valid); end
        n_vec++; if (opcode !== sw_op[2]) begin n_err++; $display("FAIL stream_opcode[2]: got %b exp %b", opcode, sw_op[2]); end
        n_vec++; if (ins_pc !== RST + 32'd8) begin n_err++; $display("FAIL stream_ins_pc[2]: got %h exp %h", ins_pc, RST + 32'd8); end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 3; k++) begin
            ins_ready = 0; imem_ack = 0;
            #1;
            n_vec++; if (ins !== sw_word[2]) begin n_err++; $display("FAIL bp_ins[%0d]: got %h exp %h", k, ins, sw_word[2]); end
            n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req[%0d]: got %b exp 0", k, imem_req); end
            n_vec++; if (imem_addr !== RST + 32'd12) begin n_err++; $display("FAIL bp_pc[%0d]: got %h exp %h", k, imem_addr, RST + 32'd12); end
            @(posedge clk); #1;
        end
        ins_ready = 1;
        #1;
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL bp_release_req: got %b exp 1", imem_req); end
        n_vec++; if (imem_addr !== RST + 32'd12) begin n_err++; $display("FAIL bp_release_addr: got %h exp %h", imem_addr, RST + 32'd12); end
        @(posedge clk); #1;
    endtask

    task automatic test_wait_states();
        logic [31:0] w3;
        logic [31:0] w4;
        w3 = 32'h0109_4020;
        w4 = 32'h2108_0001;
        for (int k = 0; k < 3; k++) begin
            ins_ready = 1'($urandom_range(1)); imem_ack = 0;
            #1;
            n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL wait_req[%0d]: got %b exp 1", k, imem_req); end
            n_vec++; if (imem_addr !== RST + 32'd12) begin n_err++; $display("FAIL wait_addr[%0d]: got %h exp %h", k, imem_addr, RST + 32'd12); end
            n_vec++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL wait_valid[%0d]: got %b exp 0", k, ins_valid); end
            @(posedge clk); #1;
        end
        imem_ack = 1; imem_rdata = w3;
        #1;
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== RST + 32'd12) begin n_err++; $display("FAIL wait_ack_cycle: req %b addr %h exp 1 %h", imem_req, imem_addr, RST + 32'd12); end
        @(posedge clk); #1;
        ins_ready = 1; imem_ack = 1; imem_rdata = w4;
        #1;
        n_vec++; if (ins_valid !== 1'b1) begin n_err++; $display("FAIL wait_valid_after_ack: got %b exp 1", ins_valid); end
        n_vec++; if (ins !== w3) begin n_err++; $display("FAIL wait_ins: got %h exp %h", ins, w3); end
        n_vec++; if (funct !== 6'b100000) begin n_err++; $display("FAIL wait_funct: got %b exp 100000", funct); end
        n_vec++; if (ins_pc !== RST + 32'd12) begin n_err++; $display("FAIL wait_ins_pc: got %h exp %h", ins_pc, RST + 32'd12); end
        n_vec++; if (imem_addr !== RST + 32'd16) begin n_err++; $display("FAIL wait_next_addr: got %h exp %h", imem_addr, RST + 32'd16); end
        @(posedge clk); #1;
        imem_ack = 0;
        #1;
        n_vec++; if (ins !== w4 || ins_pc !== RST + 32'd16) begin n_err++; $display("FAIL fifth_fetch: ins %h pc %h exp %h %h", ins, ins_pc, w4, RST + 32'd16); end
`ifdef IF_PERF_CNT_EN
        n_vec++; if (perf_fetched !== 32'd5) begin n_err++; $display("FAIL perf_fetched: got %0d exp 5", perf_fetched); end
        n_vec++; if (perf_stall !== 32'd3) begin n_err++; $display("FAIL perf_stall: got %0d exp 3", perf_stall); end
`endif
        // ready=1 and no ack: issue request for RST+20 and enter WAIT
        @(posedge clk); #1;
    endtask

    task automatic test_redirect();
        redirect_valid = 1; redirect_pc = 32'h0040_0103; imem_ack = 0;
        #1;
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== RST + 32'd20) begin n_err++; $display("FAIL redir_wait_hold: req %b addr %h exp 1 %h", imem_req, imem_addr, RST + 32'd20); end
        @(posedge clk); #1;
        redirect_valid = 0;
        #1;
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== RST + 32'd20) begin n_err++; $display("FAIL redir_flush_hold: req %b addr %h exp 1 %h", imem_req, imem_addr, RST + 32'd20); end
        n_vec++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush_valid: got %b exp 0", ins_valid); end
        @(posedge clk); #1;
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== RST + 32'd20) begin n_err++; $display("FAIL redir_flush_ack: req %b addr %h exp 1 %h", imem_req, imem_addr, RST + 32'd20); end
        @(posedge clk); #1;
        imem_ack = 0;
        #1;
        n_vec++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL redir_discard: got valid %b exp 0", ins_valid); end
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin n_err++; $display("FAIL redir_new_req: req %b addr %h exp 1 00400100", imem_req, imem_addr); end
        imem_ack = 1; imem_rdata = mem_word(32'h0040_0100);
        @(posedge clk); #1;
        imem_ack = 0;
    endtask

    task automatic test_wrap();
        logic [31:0] wa;
        logic [31:0] wb;
        wa = mem_word(32'hFFFF_FFFC);
        wb = mem_word(32'h0000_0000);
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; ins_ready = 1; imem_ack = 0;
        #1;
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL wrap_redir_req: got %b exp 0", imem_req); end
        n_vec++; if (ins_valid !== 1'b1 || ins_pc !== 32'h0040_0100) begin n_err++; $display("FAIL wrap_prev_ins: valid %b pc %h exp 1 00400100", ins_valid, ins_pc); end
        @(posedge clk); #1;
        redirect_valid = 0; imem_ack = 1; imem_rdata = wa;
        #1;
        n_vec++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL wrap_cleared: got %b exp 0", ins_valid); end
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr0: req %b addr %h exp 1 fffffffc", imem_req, imem_addr); end
        @(posedge clk); #1;
        imem_rdata = wb;
        #1;
        n_vec++; if (imem_addr !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_addr1: got %h exp 00000000", imem_addr); end
        n_vec++; if (ins !== wa || ins_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_ins0: ins %h pc %h exp %h fffffffc", ins, ins_pc, wa); end
        n_vec++; if (ins_pc_plus4 !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_plus4: got %h exp 00000000", ins_pc_plus4); end
        @(posedge clk); #1;
        imem_ack = 0; ins_ready = 0;
        #1;
        n_vec++; if (ins !== wb || ins_pc !== 32'h0 || ins_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL wrap_ins1: ins %h pc %h p4 %h exp %h 0 4", ins, ins_pc, ins_pc_plus4, wb); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] w;
        logic [31:0] prev_addr;
        bit          prev_open;
        bit          pend;
        int          cnt;
        int          xfers;
        // reset mid-operation with a same-cycle ack that must be ignored
        rst_n = 0; imem_ack = 1; imem_rdata = 32'h1234_5678; ins_ready = 1; redirect_valid = 0;
        @(posedge clk); #1;
        n_vec++; if (ins_valid !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL rand_reset: valid %b req %b exp 0 0", ins_valid, imem_req); end
        rst_n = 1; imem_ack = 0;
        exp_pc = RST; prev_open = 0; prev_addr = 0; pend = 0; cnt = 0; xfers = 0;
        for (int c = 0; c < 3000; c++) begin
            ins_ready      = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(15) == 0);
            case ($urandom_range(2))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(15));
                default: redirect_pc = RST + 32'($urandom_range(255));
            endcase
            imem_ack = 0;
            #1;
            if (prev_open) begin
                n_vec++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin n_err++; $display("FAIL rand_hold[%0d]: req %b addr %h exp 1 %h", c, imem_req, imem_addr, prev_addr); end
            end
            if (imem_req) begin
                n_vec++; if (imem_addr[1:0] !== 2'b00) begin n_err++; $display("FAIL rand_align[%0d]: addr %h", c, imem_addr); end
                if (!pend) begin pend = 1; cnt = $urandom_range(3); end
                imem_ack   = (cnt == 0);
                imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
            end else begin
                pend = 0;
            end
            #1;
            if (ins_valid && ins_ready) begin
                w = mem_word(exp_pc);
                n_vec++; if (ins_pc !== exp_pc) begin n_err++; $display("FAIL rand_ins_pc[%0d]: got %h exp %h", c, ins_pc, exp_pc); end
                n_vec++; if (ins !== w) begin n_err++; $display("FAIL rand_ins[%0d]: got %h exp %h", c, ins, w); end
                n_vec++; if (opcode !== w[31:26] || funct !== w[5:0]) begin n_err++; $display("FAIL rand_fields[%0d]: op %h fn %h exp %h %h", c, opcode, funct, w[31:26], w[5:0]); end
                n_vec++; if (ins_pc_plus4 !== exp_pc + 32'd4) begin n_err++; $display("FAIL rand_plus4[%0d]: got %h exp %h", c, ins_pc_plus4, exp_pc + 32'd4); end
                exp_pc = exp_pc + 32'd4;
                xfers++;
            end
            if (redirect_valid)
                exp_pc = {redirect_pc[31:2], 2'b00};
            prev_open = imem_req && !imem_ack;
            prev_addr = imem_addr;
            if (imem_req && !imem_ack) cnt--;
            if (imem_req && imem_ack) pend = 0;
            @(posedge clk); #1;
        end
        redirect_valid = 0; imem_ack = 0;
        n_vec++; if (xfers < 200) begin n_err++; $display("FAIL rand_progress: got %0d transfers exp >= 200", xfers); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_wait_states();
        test_redirect();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
